odo_round_key_table: RTL
========================

# odo_round_key_table

Parametrised, seed-programmable round-key store for the Odo hashing core. It replaces the fixed per-key ROMs with one table of NUM_KEYS × NUM_PERIODS round keys, each KEY_W bits wide. The table is generated in hardware from a 32-bit epoch seed, so a new epoch needs no resynthesis. It sits beside the Odo round pipeline and serves registered lookups by (key_sel, period).

## Interface
- KEY_W, default 10: round-key width; 1 ≤ KEY_W ≤ 32
- NUM_PERIODS, default 9: periods per key
- NUM_KEYS, default 4: independent key slots
- PERIOD_W, default 4: width of period; 2^PERIOD_W ≥ NUM_PERIODS
- KSEL_W, default 2: width of key_sel; 2^KSEL_W ≥ NUM_KEYS
- clk, input, 1: clock; all logic on the rising edge
- rst, input, 1: reset, asynchronous, active-high
- seed_valid, input, 1: seed offered
- seed, input, 32: epoch seed
- seed_ready, output, 1: seed accepted when seed_valid and seed_ready are both high
- busy, output, 1: fill in progress
- fill_done, output, 1: one-cycle pulse when the fill completes
- table_ready, output, 1: table valid, lookups served
- rd_en, input, 1: lookup request
- period, input, PERIOD_W: lookup period index
- key_sel, input, KSEL_W: lookup key slot
- key_out, output, KEY_W: looked-up key
- key_valid, output, 1: one-cycle pulse; key_out is valid this cycle
- bad_index, output, 1: qualifies key_valid; the index was out of range

## Operation
- FSM states:
  - EMPTY: entered on reset.
  - FILL: entered from EMPTY or READY on seed accept.
  - READY: entered from FILL after the last write.
- seed_ready = (state ≠ FILL). A seed_valid in FILL is ignored and not queued.
- Generator: 32-bit state s, step(x) = x·1103515245 + 12345 mod 2^32.
  - On accept: s ← step(seed), write index ← 0.
- Each FILL cycle:
  - Write s[31 -: KEY_W] to entry idx, then s ← step(s), idx ← idx+1.
  - idx = key_sel·NUM_PERIODS + period. Slot 0 periods 0..NUM_PERIODS−1 are written first, then slot 1, and so on.
- After write NUM_KEYS·NUM_PERIODS−1: state ← READY, fill_done pulses.
- busy = (state == FILL). table_ready = (state == READY).
- Lookup is served only when rd_en and table_ready are both high:
  - In range (period < NUM_PERIODS, key_sel < NUM_KEYS): key_out ← entry, key_valid ← 1, bad_index ← 0.
  - Out of range: key_out ← 0, key_valid ← 1, bad_index ← 1.
- rd_en while table_ready is low is ignored: key_valid stays 0 and key_out holds.
- key_out holds its last value between lookups.
- A seed accepted in READY with rd_en in the same cycle: the read is served from the old table. table_ready drops the next cycle.
- Reset mid-fill: the FSM goes to EMPTY. Table contents are don't-care and are never served until a full fill completes.

## Timing
- Reset values: seed_ready=1, busy=0, fill_done=0, table_ready=0, key_out=0, key_valid=0, bad_index=0.
- Lookup latency: 1 cycle, rd_en at edge N gives key_valid at edge N+1. Full throughput, one lookup per cycle.
- Fill latency: seed accepted at edge T. busy is high for edges T+1 … T+NUM_KEYS·NUM_PERIODS. fill_done and table_ready rise at edge T+NUM_KEYS·NUM_PERIODS.
- With defaults the fill takes 36 cycles.
- Table storage is written synchronously with one write port and one read port. No read-during-write collision occurs, because reads are blocked in FILL.

## Test plan
- Reset, then rd_en with period=0, key_sel=0 → key_valid stays 0, key_out=0, seed_ready=1, table_ready=0.
- Seed 0x00000000 at T → busy for 36 cycles; fill_done and table_ready rise at T+36. Lookups then return:
  - (key_sel 0, period 0) → 0x000
  - (key_sel 0, period 1) → 0x34F
- Back-to-back lookups over all 36 valid indices with defaults → one key_valid per cycle, values match a bit-true LCG model. Also read period=9 and key_sel=0 → key_out=0, bad_index=1.
- During FILL:
  - A new seed_valid is ignored; the table matches the first seed.
  - A seed accepted in READY alongside rd_en → the read returns the old-table value, table_ready=0 the next cycle.
  - After the refill, the table matches the new seed.
- Assert rst at FILL cycle 10 → all outputs reach reset values immediately. A fresh seed afterwards gives a correct full table.
- Parameter sweep KEY_W=16, NUM_PERIODS=5, NUM_KEYS=3 → 15-cycle fill, keys = s[31:16]. period=5 gives bad_index=1.

Source files
------------

// File: rtl/odo_round_key_table.sv
`default_nettype none
// ============================================================================
// Module  : odo_round_key_table
// Purpose : Seed-programmable NUM_KEYS x NUM_PERIODS round-key table, filled by
//           an LCG from a 32-bit epoch seed, with registered 1-cycle lookups.
// Revision: 1.0 - initial release
// ============================================================================
module odo_round_key_table #(
  parameter int KEY_W       = 10,
  parameter int NUM_PERIODS = 9,
  parameter int NUM_KEYS    = 4,
  parameter int PERIOD_W    = 4,
  parameter int KSEL_W      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_valid,
  input  logic [31:0]         seed,
  output logic                seed_ready,
  output logic                busy,
  output logic                fill_done,
  output logic                table_ready,
  input  logic                rd_en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [KSEL_W-1:0]   key_sel,
  output logic [KEY_W-1:0]    key_out,
  output logic                key_valid,
  output logic                bad_index
);

  localparam int c_DEPTH = NUM_KEYS * NUM_PERIODS;
  localparam int c_IDX_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam logic [c_IDX_W-1:0]  c_LAST = c_IDX_W'(c_DEPTH - 1);
  localparam logic [PERIOD_W:0]   c_NP   = (PERIOD_W + 1)'(NUM_PERIODS);
  localparam logic [KSEL_W:0]     c_NK   = (KSEL_W + 1)'(NUM_KEYS);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_READY = 2'd2;

  function automatic logic [31:0] f_step(input logic [31:0] x);
    return x * 32'd1103515245 + 32'd12345;
  endfunction

  logic [1:0]         r_state;
  logic [31:0]        r_s;
  logic [c_IDX_W-1:0] r_widx;
  logic               r_fill_done;
  logic [KEY_W-1:0]   r_key_out;
  logic               r_key_valid;
  logic               r_bad_index;
  logic [KEY_W-1:0]   r_mem [c_DEPTH];

  logic [c_IDX_W-1:0] w_rd_idx;
  logic               w_in_range;

  assign w_rd_idx   = c_IDX_W'(key_sel) * c_IDX_W'(NUM_PERIODS) + c_IDX_W'(period);
  assign w_in_range = ({1'b0, period} < c_NP) && ({1'b0, key_sel} < c_NK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_EMPTY;
      r_s         <= 32'd0;
      r_widx      <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_state)
        c_FILL: begin
          r_s    <= f_step(r_s);
          r_widx <= r_widx + 1'b1;
          if (r_widx == c_LAST) begin
            r_state     <= c_READY;
            r_fill_done <= 1'b1;
          end
        end
        default: begin
          // Seeds offered during FILL are dropped, never queued.
          if (seed_valid) begin
            r_state <= c_FILL;
            r_s     <= f_step(seed);
            r_widx  <= '0;
          end
        end
      endcase
    end
  end

  // Table storage carries no reset; contents are only exposed once READY.
  always_ff @(posedge clk) begin
    if (r_state == c_FILL) begin
      r_mem[r_widx] <= r_s[31 -: KEY_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_bad_index <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_bad_index <= 1'b0;
      if (rd_en && (r_state == c_READY)) begin
        r_key_valid <= 1'b1;
        if (w_in_range) begin
          r_key_out <= r_mem[w_rd_idx];
        end else begin
          r_key_out   <= '0;
          r_bad_index <= 1'b1;
        end
      end
    end
  end

  assign seed_ready  = (r_state != c_FILL);
  assign busy        = (r_state == c_FILL);
  assign table_ready = (r_state == c_READY);
  assign fill_done   = r_fill_done;
  assign key_out     = r_key_out;
  assign key_valid   = r_key_valid;
  assign bad_index   = r_bad_index;

endmodule
`default_nettype wire
